sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Time-multiplexed scan driver for the board's common-anode hexadecimal display. It consumes the packed segment patterns held by the seven-segment MMIO register bank and drives the shared cathode bus plus one anode per digit. Each digit is lit in turn for a fixed slot, with a programmable blanking gap between digits to prevent ghosting. The block sits between the register bank and the top-level display pins.

## Interface
- DIGITS, 8, number of digits scanned; 1..16
- PRESCALE, 4096, clock cycles per digit slot; must be >= 2
- BLANK, 256, cycles at the start of each slot with all anodes off; 0 <= BLANK < PRESCALE
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  1 = scanning; 0 = display dark and scan state held at start
- digit_en  input  DIGITS  per-digit lit mask; bit i = 0 keeps digit i dark but its slot still elapses
- sevenseg  input  7*DIGITS  packed active-low patterns; digit i at [7*i+6:7*i]
- an  output  DIGITS  active-low anode drives, registered
- seg  output  7  active-low cathode drive, registered
- frame_tick  output  1  one-cycle pulse at the start of each full scan, registered

## Operation
- State: slot counter cnt (width $clog2(PRESCALE)) and digit index idx (width $clog2(DIGITS), min 1).
- cnt counts 0..PRESCALE-1, then wraps to 0 and idx advances; idx wraps DIGITS-1 -> 0.
- Slot start (cnt becomes 0): seg loads sevenseg[7*idx_next+6:7*idx_next]. The pattern is held for the whole slot; mid-slot changes to sevenseg do not appear until the next slot of that digit.
- Blanking: an is all ones while cnt < BLANK.
- Lit phase: when cnt becomes BLANK, an[idx] goes low if digit_en[idx] = 1. All other anodes stay high.
- At most one anode is low in any cycle; this is an invariant.
- digit_en is sampled on the edge where the lit phase starts; a change mid-slot takes effect at the next slot.
- frame_tick = 1 for exactly the cycle in which idx = 0 and cnt = 0, while enable = 1.
- enable = 0:
  - cnt and idx are synchronously forced to 0.
  - an is all ones, seg = 7'h7F, frame_tick = 0.
- enable rising: scanning restarts at digit 0, cnt 0, with a full slot.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - cnt = 0, idx = 0
  - an = all ones, seg = 7'h7F, frame_tick = 0
- First edge after rst_n deasserts with enable = 1:
  - seg loads the digit-0 pattern.
  - frame_tick pulses.
  - If BLANK = 0, an[0] goes low on that same edge.
- BLANK = 0: the lit phase starts on the slot-start edge; there is no dark cycle between digits.
- Slot length is exactly PRESCALE cycles; frame period is DIGITS*PRESCALE cycles.
- The outputs are registers, so there is no combinational path from inputs to pins.
- rst_n asserted mid-slot: outputs go dark immediately (asynchronously); after release, the scan restarts at digit 0.
- enable dropped mid-slot: outputs go dark on the next edge.

## Structure
- Shared package sevenseg_pkg holds:
  - SEG_BLANK = 7'h7F
  - the active-low convention constants, ANODE_OFF and ANODE_ON
  - the pattern width constant SEG_W = 7
- One sub-module, sevenseg_scan_timer, holds cnt and idx and produces:
  - slot_start (cnt = 0)
  - lit_start (cnt = BLANK)
  - frame_start
  - idx
- The top level holds the an, seg and frame_tick registers and the pattern multiplexer.

## Test plan
All scenarios use DIGITS=4, PRESCALE=8, BLANK=2.
- Reset: hold rst_n = 0 -> an = 4'hF, seg = 7'h7F, frame_tick = 0; assert rst_n mid-slot -> outputs return to these values without waiting for a clock edge.
- Scan order: sevenseg = {7'h12, 7'h30, 7'h79, 7'h40}, digit_en = 4'hF, enable = 1. Required sequence:
  - an steps 4'hE, 4'hD, 4'hB, 4'h7.
  - Each value lasts 6 cycles and is preceded by 2 cycles of 4'hF.
  - seg = 7'h40, 7'h79, 7'h30, 7'h12 in turn.
  - frame_tick pulses every 32 cycles.
- Masking: digit_en = 4'b0101 -> an[1] and an[3] are never low; the frame period stays 32 cycles.
- Tearing: change digit 2's pattern from 7'h30 to 7'h24 at cnt = 4 of slot 2 -> seg stays 7'h30 until the slot ends; 7'h24 appears at the next slot-2 start.
- Enable: drop enable during slot 3 -> an = 4'hF and seg = 7'h7F on the next edge; re-raise it -> a frame_tick pulse and digit 0 restart on the first enabled edge.
- Edge parameter: BLANK = 0 -> an is never 4'hF between slots; exactly one anode is low in every enabled cycle.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants for the seven-segment scan driver.
package sevenseg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic ANODE_OFF = 1'b1;
  localparam logic ANODE_ON = 1'b0;
endpackage

// File: rtl/sevenseg_scan_timer.sv
// sevenseg_scan_timer: slot counter and digit index with slot/lit/frame strobes.
module sevenseg_scan_timer #(
  parameter int DIGITS = 8,
  parameter int PRESCALE = 4096,
  parameter int BLANK = 256,
  parameter int CW = $clog2(PRESCALE),
  parameter int IW = DIGITS > 1 ? $clog2(DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic          slot_start,
  output logic          lit_start,
  output logic          frame_start,
  output logic [IW-1:0] idx
);
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CW'(PRESCALE - 1);
  assign slot_start = cnt == '0;
  assign lit_start = cnt == CW'(BLANK);
  assign frame_start = slot_start && idx == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!enable) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed common-anode display driver with blanking gap.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int PRESCALE = 4096,
  parameter int BLANK = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [DIGITS-1:0]       digit_en,
  input  logic [SEG_W*DIGITS-1:0] sevenseg,
  output logic [DIGITS-1:0]       an,
  output logic [SEG_W-1:0]        seg,
  output logic                    frame_tick
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic slot_start, lit_start, frame_start;
  logic [IW-1:0] idx;
  logic [SEG_W-1:0] pats [DIGITS];
  logic [DIGITS-1:0] an_lit;
  sevenseg_scan_timer #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK(BLANK), .CW(CW), .IW(IW)
  ) u_timer (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .slot_start(slot_start), .lit_start(lit_start),
    .frame_start(frame_start), .idx(idx)
  );
  for (genvar g = 0; g < DIGITS; g++) assign pats[g] = sevenseg[SEG_W*g +: SEG_W];
  always_comb begin
    an_lit = {DIGITS{ANODE_OFF}};
    if (digit_en[idx]) an_lit[idx] = ANODE_ON;
  end
  // Outputs trail the counter by one edge; with BLANK = 0 lit_start wins over the slot-start blanking.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      an <= {DIGITS{ANODE_OFF}};
      seg <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      an <= {DIGITS{ANODE_OFF}};
      seg <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (slot_start) seg <= pats[idx];
      an <= lit_start ? an_lit : slot_start ? {DIGITS{ANODE_OFF}} : an;
    end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed checks of scan order, masking, tearing, enable and BLANK = 0.
module tb_sevenseg_scan;
  logic clk = 0, rst_n = 0, enable = 1;
  logic [3:0] digit_en = 4'hF;
  logic [27:0] sevenseg = {7'h12, 7'h30, 7'h79, 7'h40};
  logic [3:0] an, an0;
  logic [6:0] seg, seg0;
  logic frame_tick, frame_tick0;
  logic [6:0] pat [4];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(.DIGITS(4), .PRESCALE(8), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digit_en(digit_en),
    .sevenseg(sevenseg), .an(an), .seg(seg), .frame_tick(frame_tick)
  );
  sevenseg_scan #(.DIGITS(4), .PRESCALE(8), .BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digit_en(digit_en),
    .sevenseg(sevenseg), .an(an0), .seg(seg0), .frame_tick(frame_tick0)
  );

  function automatic logic [3:0] exp_an(int k, int blank, logic [3:0] mask);
    logic [3:0] r;
    int s;
    s = (k / 8) % 4;
    r = 4'hF;
    if (k % 8 >= blank && mask[s]) r[s] = 1'b0;
    return r;
  endfunction

  task automatic restart();
    @(posedge clk); #1 enable = 0;
    @(posedge clk); #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL restart_dark: an=%h seg=%h ft=%b, required an=f seg=7f ft=0", an, seg, frame_tick);
    end
    enable = 1;
  endtask

  task automatic test_reset();
    #22;
    checks++;
    if (an !== 4'hF) begin fails++; $display("FAIL reset_an: got %h, required f", an); end
    checks++;
    if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg: got %h, required 7f", seg); end
    checks++;
    if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_ft: got %b, required 0", frame_tick); end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_scan();
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      checks++;
      if (an !== exp_an(k, 2, 4'hF)) begin fails++; $display("FAIL scan_an k=%0d: got %h, required %h", k, an, exp_an(k, 2, 4'hF)); end
      checks++;
      if (seg !== pat[(k / 8) % 4]) begin fails++; $display("FAIL scan_seg k=%0d: got %h, required %h", k, seg, pat[(k / 8) % 4]); end
      checks++;
      if (frame_tick !== (k % 32 == 0)) begin fails++; $display("FAIL scan_ft k=%0d: got %b, required %b", k, frame_tick, k % 32 == 0); end
      checks++;
      if (an0 !== exp_an(k, 0, 4'hF)) begin fails++; $display("FAIL scan_an_blank0 k=%0d: got %h, required %h", k, an0, exp_an(k, 0, 4'hF)); end
    end
  endtask

  task automatic test_masking();
    digit_en = 4'b0101;
    restart();
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      checks++;
      if (an !== exp_an(k, 2, 4'b0101)) begin fails++; $display("FAIL mask_an k=%0d: got %h, required %h", k, an, exp_an(k, 2, 4'b0101)); end
      checks++;
      if (frame_tick !== (k % 32 == 0)) begin fails++; $display("FAIL mask_ft k=%0d: got %b, required %b", k, frame_tick, k % 32 == 0); end
    end
    digit_en = 4'hF;
  endtask

  task automatic test_tearing();
    logic [6:0] e;
    restart();
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      e = (k >= 48 && k < 56) ? 7'h24 : pat[(k / 8) % 4];
      checks++;
      if (seg !== e) begin fails++; $display("FAIL tear_seg k=%0d: got %h, required %h", k, seg, e); end
      if (k == 20) sevenseg[20:14] = 7'h24;
    end
    sevenseg[20:14] = 7'h30;
  endtask

  task automatic test_enable();
    restart();
    for (int k = 0; k < 28; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (an !== 4'h7) begin fails++; $display("FAIL en_pre_an: got %h, required 7", an); end
    enable = 0;
    @(posedge clk); #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL en_drop: an=%h seg=%h ft=%b, required an=f seg=7f ft=0", an, seg, frame_tick);
    end
    enable = 1;
    @(posedge clk); #1;
    checks++;
    if (frame_tick !== 1'b1 || seg !== 7'h40 || an !== 4'hF) begin
      fails++;
      $display("FAIL en_restart: an=%h seg=%h ft=%b, required an=f seg=40 ft=1", an, seg, frame_tick);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (an !== 4'hE || frame_tick !== 1'b0) begin fails++; $display("FAIL en_lit0: an=%h ft=%b, required an=e ft=0", an, frame_tick); end
  endtask

  task automatic test_async_reset();
    restart();
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (an !== 4'hD) begin fails++; $display("FAIL arst_pre_an: got %h, required d", an); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL arst_dark: an=%h seg=%h ft=%b, required an=f seg=7f ft=0", an, seg, frame_tick);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (frame_tick !== 1'b1 || seg !== 7'h40 || an !== 4'hF) begin
      fails++;
      $display("FAIL arst_restart: an=%h seg=%h ft=%b, required an=f seg=40 ft=1", an, seg, frame_tick);
    end
  endtask

  task automatic test_blank0();
    restart();
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      checks++;
      if ($countones(~an0) != 1) begin fails++; $display("FAIL blank0_onehot k=%0d: an=%h, required exactly one low", k, an0); end
      checks++;
      if (seg0 !== pat[k / 8]) begin fails++; $display("FAIL blank0_seg k=%0d: got %h, required %h", k, seg0, pat[k / 8]); end
    end
  endtask

  initial begin
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h30; pat[3] = 7'h12;
    test_reset();
    test_scan();
    test_masking();
    test_tearing();
    test_enable();
    test_async_reset();
    test_blank0();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
